// File: rtl/axis_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_gen
// Description : AXI4-Stream frame source emitting an incrementing-count frame
//               per command, with bad-frame marking and abort truncation.
//               Define AXIS_FRAME_GEN_STATS_EN to add good-frame/abort counters.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = (DATA_WIDTH/8),
    parameter int LEN_WIDTH  = 16,
    parameter int USER_WIDTH = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic [USER_WIDTH-1:0] USER_GOOD_VALUE      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    input  logic                  cmd_bad,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
`ifdef AXIS_FRAME_GEN_STATS_EN
    output logic [15:0]           stat_frames,
    output logic [15:0]           stat_aborts,
`endif
    output logic                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  r_state;
    logic [LEN_WIDTH-1:0]    r_remaining;
    logic                    r_bad;
    logic                    r_abort_pending;
    logic                    r_abort_beat;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [USER_WIDTH-1:0]   r_tuser;

    logic                    w_xfer;
    logic                    w_end_abort;
    logic [LEN_WIDTH-1:0]    w_rem_next;
    logic                    w_next_last;

    assign w_xfer      = r_tvalid & m_axis_tready;
    assign w_end_abort = r_abort_pending | abort;
    assign w_rem_next  = r_remaining - LEN_WIDTH'(1);
    assign w_next_last = (w_rem_next == '0) | w_end_abort;

    // r_remaining counts beats still to follow the one being presented
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_remaining     <= '0;
            r_bad           <= 1'b0;
            r_abort_pending <= 1'b0;
            r_abort_beat    <= 1'b0;
            r_tvalid        <= 1'b0;
            r_tlast         <= 1'b0;
            r_tdata         <= '0;
            r_tuser         <= USER_GOOD_VALUE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_state         <= ST_SEND;
                        r_remaining     <= cmd_len;
                        r_bad           <= cmd_bad;
                        r_tdata         <= cmd_seed;
                        r_tvalid        <= 1'b1;
                        r_tlast         <= (cmd_len == '0);
                        r_tuser         <= ((cmd_len == '0) && cmd_bad) ?
                                           USER_BAD_FRAME_VALUE : USER_GOOD_VALUE;
                        r_abort_pending <= 1'b0;
                        r_abort_beat    <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (r_tlast) begin
                            r_state         <= ST_IDLE;
                            r_tvalid        <= 1'b0;
                            r_tlast         <= 1'b0;
                            r_tuser         <= USER_GOOD_VALUE;
                            r_abort_pending <= 1'b0;
                            r_abort_beat    <= 1'b0;
                        end else begin
                            r_tdata         <= r_tdata + DATA_WIDTH'(1);
                            r_remaining     <= w_rem_next;
                            r_tlast         <= w_next_last;
                            r_tuser         <= (w_end_abort || ((w_rem_next == '0) && r_bad)) ?
                                               USER_BAD_FRAME_VALUE : USER_GOOD_VALUE;
                            r_abort_beat    <= w_end_abort;
                            r_abort_pending <= 1'b0;
                        end
                    end else if (abort && !r_tlast) begin
                        // Held beat stays untouched; truncation applies to the next one
                        r_abort_pending <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXIS_FRAME_GEN_STATS_EN
    logic [15:0] r_stat_frames;
    logic [15:0] r_stat_aborts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_frames <= '0;
            r_stat_aborts <= '0;
        end else if (w_xfer && r_tlast) begin
            if (r_abort_beat) begin
                if (r_stat_aborts != 16'hFFFF)
                    r_stat_aborts <= r_stat_aborts + 16'd1;
            end else if (!r_bad) begin
                if (r_stat_frames != 16'hFFFF)
                    r_stat_frames <= r_stat_frames + 16'd1;
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_aborts = r_stat_aborts;
`endif

    assign cmd_ready     = (r_state == ST_IDLE);
    assign busy          = (r_state == ST_SEND);
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = {KEEP_WIDTH{1'b1}};
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;

endmodule
`default_nettype wire
